// File: rtl/vbuffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vbuffer_pkg
//  Purpose  : Shared definitions for the vertex-buffer fetch block: fetch
//             FSM state encoding and the vertex word field layout
//             (VECS vectors x COMPS components x COMP_W bits).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vbuffer_pkg;

    localparam int COMP_W = 18;
    localparam int COMPS  = 3;
    localparam int VECS   = 4;
    localparam int VEC_W  = COMP_W * COMPS;
    localparam int WORD_W = VEC_W * VECS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Bit offset of component `comp` of vector `vec` inside a vertex word.
    function automatic int comp_lsb(input int vec, input int comp);
        return vec * VEC_W + comp * COMP_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vbuffer_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : vbuffer_fetch_if
//  Purpose  : Downstream valid/ready stream carrying fetched vertex words.
//  Signals  : out_valid  - word available (master -> slave)
//             out_ready  - consumer accepts (slave -> master)
//             out_data   - vertex word, DATA_WIDTH bits
//             out_index  - 0-based ordinal of the word within the run
//             out_last   - final word of the run
//  Revision : 1.0 - initial release
// ============================================================================
interface vbuffer_fetch_if
    import vbuffer_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = 12
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/vbuffer_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vbuffer_fetch_fifo
//  Purpose  : Two-entry output FIFO holding fetched words with their index
//             and last tag. Push and pop may happen in the same cycle even
//             when full; the head is held stable until popped.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             i_push, i_push_*    - write strobe and entry payload
//             i_pop               - consume the head entry
//             o_head_*            - head entry payload
//             o_full, o_empty     - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module vbuffer_fetch_fifo #(
    parameter int DATA_WIDTH  = 216,
    parameter int INDEX_WIDTH = 13
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic [DATA_WIDTH-1:0]  i_push_data,
    input  wire logic [INDEX_WIDTH-1:0] i_push_index,
    input  wire logic                   i_push_last,
    input  wire logic                   i_pop,
    output logic      [DATA_WIDTH-1:0]  o_head_data,
    output logic      [INDEX_WIDTH-1:0] o_head_index,
    output logic                        o_head_last,
    output logic                        o_full,
    output logic                        o_empty
);

    logic [DATA_WIDTH-1:0]  r_data  [0:1];
    logic [INDEX_WIDTH-1:0] r_index [0:1];
    logic                   r_last  [0:1];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_index[0] <= '0;
            r_index[1] <= '0;
            r_last[0]  <= 1'b0;
            r_last[1]  <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr]  <= i_push_data;
                r_index[r_wr_ptr] <= i_push_index;
                r_last[r_wr_ptr]  <= i_push_last;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data  = r_data[r_rd_ptr];
    assign o_head_index = r_index[r_rd_ptr];
    assign o_head_last  = r_last[r_rd_ptr];
    assign o_full       = (r_count == 2'd2);
    assign o_empty      = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/vbuffer_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : vbuffer_fetch
//  Purpose  : Streams `count` consecutive vertex-buffer words starting at
//             `base_addr` (address wraps modulo 2^ADDR_WIDTH) out through a
//             valid/ready interface, one word per cycle when unstalled.
//  Ports    : clock, reset - rising-edge clock, asynchronous active-high reset
//             start        - one-cycle run request (honoured only when idle)
//             base_addr    - first word address, sampled on accepted start
//             count        - words to fetch (0..2^ADDR_WIDTH)
//             read_addr    - buffer read address
//             q            - buffer read data, valid one clock after read_addr
//             busy, done   - run in progress / one-cycle completion pulse
//             out          - output word stream (master side)
//  Revision : 1.0 - initial release
// ============================================================================
module vbuffer_fetch
    import vbuffer_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    input  wire logic [ADDR_WIDTH:0]   count,
    output logic      [ADDR_WIDTH-1:0] read_addr,
    input  wire logic [DATA_WIDTH-1:0] q,
    output logic                       busy,
    output logic                       done,
    vbuffer_fetch_if.master            out
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         w_accept;
    logic         w_done_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_issued;
    logic                  r_inflight;
    logic [ADDR_WIDTH:0]   r_inflight_index;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic [1:0]            w_fifo_occ;
    logic [1:0]            w_credit;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH:0]   w_head_index;
    logic                  w_head_last;

    // ------------------------------------------------------------------
    // Issue control. Words in flight plus words buffered may never exceed
    // the two FIFO slots; a pop this cycle frees a slot before the next
    // capture, which is what sustains one word per cycle when unstalled.
    // ------------------------------------------------------------------
    assign w_pop        = out.out_valid && out.out_ready;
    assign w_fifo_occ   = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
    assign w_credit     = {1'b0, r_inflight} + w_fifo_occ - {1'b0, w_pop};
    assign w_issue      = (r_state == ST_RUN) && (r_issued < r_count) &&
                          (w_credit < 2'd2);
    assign w_issue_last = (r_issued == (r_count - 1'b1));

    assign read_addr    = r_base + r_issued[ADDR_WIDTH-1:0];
    assign busy         = (r_state == ST_RUN);
    assign done         = r_done;

    // ------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    // An empty run completes immediately without reads.
                    if (count != '0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run bookkeeping and the one-cycle read pipeline stage
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_base           <= '0;
            r_count          <= '0;
            r_issued         <= '0;
            r_inflight       <= 1'b0;
            r_inflight_index <= '0;
            r_inflight_last  <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base   <= base_addr;
                r_count  <= count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end
            // q for the address issued now is captured on the next edge.
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_index <= r_issued;
                r_inflight_last  <= w_issue_last;
            end
            r_done <= w_done_next;
        end
    end

    vbuffer_fetch_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (ADDR_WIDTH + 1)
    ) u_fifo (
        .clk          (clock),
        .rst          (reset),
        .i_push       (r_inflight),
        .i_push_data  (q),
        .i_push_index (r_inflight_index),
        .i_push_last  (r_inflight_last),
        .i_pop        (w_pop),
        .o_head_data  (w_head_data),
        .o_head_index (w_head_index),
        .o_head_last  (w_head_last),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    assign out.out_valid = !w_fifo_empty;
    assign out.out_data  = w_head_data;
    assign out.out_index = w_head_index;
    assign out.out_last  = w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_vbuffer_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vbuffer_fetch
//  Purpose  : Self-checking bench for vbuffer_fetch. The vertex buffer is a
//             synchronous-read memory whose word content is a function of
//             its address; expected output streams are the buffer words at
//             (base + n) mod 4096 in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vbuffer_fetch;
    import vbuffer_pkg::*;

    localparam int c_dw = 216;
    localparam int c_aw = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [c_aw-1:0]   base_addr;
    logic [c_aw:0]     count;
    logic [c_aw-1:0]   read_addr;
    logic [c_dw-1:0]   q;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    vbuffer_fetch_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) out_if ();

    vbuffer_fetch #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .read_addr (read_addr),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .out       (out_if)
    );

    always #5 clock = ~clock;

    // Each component holds {address, vector, component, 2'b01}.
    function automatic logic [c_dw-1:0] ram_word(input logic [c_aw-1:0] a);
        logic [c_dw-1:0] w;
        w = '0;
        for (int k = 0; k < VECS; k++) begin
            for (int c = 0; c < COMPS; c++) begin
                w[comp_lsb(k, c) +: COMP_W] = {a, 2'(k), 2'(c), 2'b01};
            end
        end
        return w;
    endfunction

    always @(posedge clock) q <= ram_word(read_addr);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [c_dw-1:0] act,
                         input logic [c_dw-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, out_if.out_valid, 1'b0);
        check({tag, "_last"},  out_if.out_last,  1'b0);
        check({tag, "_index"}, out_if.out_index, '0);
        check({tag, "_data"},  out_if.out_data,  '0);
        check({tag, "_raddr"}, read_addr,        '0);
        check({tag, "_busy"},  busy,             1'b0);
        check({tag, "_done"},  done,             1'b0);
    endtask

    // Runs one fetch with random back-pressure and compares every transfer
    // against the expected word list. Optionally pulses a stray start
    // (different base/count) at cycle glitch_k of the run.
    task automatic run_stream(input logic [c_aw-1:0] b, input logic [c_aw:0] n,
                              input int pct, input int glitch_k, input string tag);
        logic [c_dw-1:0] exp_data [$];
        logic [c_dw-1:0] held_data;
        logic [c_aw:0]   held_index;
        logic            held_last;
        bit              stalled;
        bit              finished;
        int              got;
        for (int i = 0; i < int'(n); i++) exp_data.push_back(ram_word(12'(int'(b) + i)));
        base_addr = b;
        count     = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        stalled   = 1'b0;
        finished  = 1'b0;
        got       = 0;
        held_data = '0;
        held_index = '0;
        held_last = 1'b0;
        for (int cyc = 0; cyc < 40 * int'(n) + 50 && !finished; cyc++) begin
            if (cyc == glitch_k) begin
                base_addr = ~b;
                count     = 13'd2;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            out_if.out_ready = ($urandom_range(99) < pct);
            check($sformatf("%s_occ", tag), dut.u_fifo.r_count > 2'd2, 1'b0);
            if (stalled) begin
                check($sformatf("%s_hold_valid", tag), out_if.out_valid, 1'b1);
                check($sformatf("%s_hold_data", tag),  out_if.out_data,  held_data);
                check($sformatf("%s_hold_index", tag), out_if.out_index, held_index);
                check($sformatf("%s_hold_last", tag),  out_if.out_last,  held_last);
            end
            if (done) begin
                check($sformatf("%s_count_at_done", tag), got, int'(n));
                check($sformatf("%s_busy_at_done", tag), busy, 1'b0);
                finished = 1'b1;
            end else begin
                check($sformatf("%s_busy", tag), busy, 1'b1);
                if (out_if.out_valid) begin
                    if (got >= int'(n)) begin
                        fail_now($sformatf("%s_extra_word index=%0d", tag, out_if.out_index));
                    end else if (out_if.out_ready) begin
                        check($sformatf("%s_data%0d", tag, got),  out_if.out_data,  exp_data[got]);
                        check($sformatf("%s_index%0d", tag, got), out_if.out_index, got);
                        check($sformatf("%s_last%0d", tag, got),  out_if.out_last,
                              (got == int'(n) - 1));
                        got++;
                    end
                end
            end
            stalled    = out_if.out_valid && !out_if.out_ready;
            held_data  = out_if.out_data;
            held_index = out_if.out_index;
            held_last  = out_if.out_last;
            tick();
        end
        start = 1'b0;
        if (!finished) fail_now($sformatf("%s_timeout got=%0d", tag, got));
        check($sformatf("%s_done_pulse", tag), done, 1'b0);
        check($sformatf("%s_idle_valid", tag), out_if.out_valid, 1'b0);
    endtask

    typedef struct {
        bit            chk_addr;
        logic [c_aw-1:0] addr;
        logic          valid;
        logic [c_aw:0] index;
        logic          last;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t            tbl [8];
    logic [c_aw-1:0] wrap_addr [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // base=5, count=4, out_ready held high; row k is the k-th cycle
        // after the start edge.
        tbl[0] = '{1'b1, 12'd5, 1'b0, 13'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 12'd6, 1'b0, 13'd0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 12'd7, 1'b1, 13'd0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 12'd8, 1'b1, 13'd1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 12'd0, 1'b1, 13'd2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 12'd0, 1'b1, 13'd3, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 12'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 12'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0};
        wrap_addr[0] = 12'd4094;
        wrap_addr[1] = 12'd4095;
        wrap_addr[2] = 12'd0;

        reset            = 1'b1;
        start            = 1'b0;
        base_addr        = '0;
        count            = '0;
        out_if.out_ready = 1'b0;
        tick();
        tick();
        check_reset_state("por");
        reset = 1'b0;
        tick();

        // Table-driven: base=5 count=4, ready high.
        out_if.out_ready = 1'b1;
        base_addr = 12'd5;
        count     = 13'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].chk_addr) check($sformatf("t1_raddr_k%0d", k), read_addr, tbl[k].addr);
            check($sformatf("t1_valid_k%0d", k), out_if.out_valid, tbl[k].valid);
            check($sformatf("t1_busy_k%0d", k),  busy, tbl[k].busy);
            check($sformatf("t1_done_k%0d", k),  done, tbl[k].done);
            if (tbl[k].valid) begin
                check($sformatf("t1_index_k%0d", k), out_if.out_index, tbl[k].index);
                check($sformatf("t1_last_k%0d", k),  out_if.out_last,  tbl[k].last);
                check($sformatf("t1_data_k%0d", k),  out_if.out_data,
                      ram_word(12'(5 + int'(tbl[k].index))));
            end
            tick();
        end

        // Address wrap: base=4094, count=3.
        base_addr = 12'd4094;
        count     = 13'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) check($sformatf("t2_raddr_k%0d", k), read_addr, wrap_addr[k]);
            if (k >= 2 && k < 5) begin
                check($sformatf("t2_valid_k%0d", k), out_if.out_valid, 1'b1);
                check($sformatf("t2_data_k%0d", k),  out_if.out_data, ram_word(wrap_addr[k-2]));
                check($sformatf("t2_last_k%0d", k),  out_if.out_last, (k == 4));
            end
            if (k == 5) check("t2_done", done, 1'b1);
            tick();
        end

        // Empty run: done next cycle, never valid.
        base_addr = 12'd33;
        count     = 13'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_valid", out_if.out_valid, 1'b0);
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("t3_valid_k%0d", k), out_if.out_valid, 1'b0);
            check($sformatf("t3_done_k%0d", k),  done, 1'b0);
        end

        // count=8 with 30% ready.
        run_stream(12'($urandom_range(4095)), 13'd8, 30, -1, "t4");
        // Stray start during a run must be ignored.
        run_stream(12'd100, 13'd5, 100, 1, "t5a");
        run_stream(12'd4093, 13'd6, 50, 2, "t5b");

        // Reset after two transfers of a count=6 run.
        out_if.out_ready = 1'b1;
        base_addr = 12'd50;
        count     = 13'd6;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_pre_valid", out_if.out_valid, 1'b1);
        check("t6_pre_index", out_if.out_index, 13'd2);
        reset = 1'b1;
        #1;
        check_reset_state("t6_rst");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6_post_valid_k%0d", k), out_if.out_valid, 1'b0);
            tick();
        end
        run_stream(12'd0, 13'd1, 100, -1, "t6b");

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            run_stream(12'($urandom_range(4095)), 13'($urandom_range(12, 1)),
                       int'($urandom_range(100, 20)), -1, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
